// File: rtl/axi_rab_pkg.sv
// Shared AXI RAB definitions: RRESP codes and the layout of a dropped-transaction entry.
package axi_rab_pkg;

    typedef enum logic [1:0] {
        RespOkay   = 2'b00,
        RespExokay = 2'b01,
        RespSlverr = 2'b10,
        RespDecerr = 2'b11
    } axi_resp_e;

    localparam int unsigned DropLenWidth = 8;

    // Drop entry is {id, len}; len occupies the low DropLenWidth bits.
    function automatic int unsigned drop_entry_width(input int unsigned id_width);
        return id_width + DropLenWidth;
    endfunction

endpackage

// File: rtl/axi_buffer_rab.sv
// Small synchronous FIFO with valid/ready on both sides; ready_out is derived from the
// registered occupancy, so a pop on a full buffer frees space only from the next cycle.
module axi_buffer_rab #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned BUFFER_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    input  logic                  ready_in,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  ready_out
);

    localparam int unsigned PtrWidth = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
    localparam logic [PtrWidth:0]   CntFull = (PtrWidth + 1)'(BUFFER_DEPTH);
    localparam logic [PtrWidth-1:0] PtrLast = PtrWidth'(BUFFER_DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem_q [BUFFER_DEPTH];
    logic [PtrWidth-1:0]   wr_ptr_q, rd_ptr_q;
    logic [PtrWidth:0]     count_q;
    logic                  push, pop;

    assign ready_out = (count_q != CntFull);
    assign valid_out = (count_q != '0);
    assign data_out  = mem_q[rd_ptr_q];
    assign push      = valid_in & ready_out;
    assign pop       = ready_in & valid_out;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

endmodule

// File: rtl/axi4_rdrop_responder.sv
// Injects SLVERR read bursts for dropped reads, interleaved at burst boundaries with
// genuine R traffic from the master port.
module axi4_rdrop_responder
    import axi_rab_pkg::*;
#(
    parameter int unsigned C_AXI_ID_WIDTH   = 10,
    parameter int unsigned C_AXI_DATA_WIDTH = 64,
    parameter int unsigned C_AXI_USER_WIDTH = 4,
    parameter logic [1:0]  C_DROP_RESP      = RespSlverr
) (
    input  logic                        axi4_aclk,
    input  logic                        axi4_arstn,

    input  logic [C_AXI_ID_WIDTH-1:0]   trans_id,
    input  logic [7:0]                  trans_len,
    input  logic                        trans_drop,
    output logic                        drop_ready,

    output logic [C_AXI_ID_WIDTH-1:0]   s_axi4_rid,
    output logic [C_AXI_DATA_WIDTH-1:0] s_axi4_rdata,
    output logic [1:0]                  s_axi4_rresp,
    output logic                        s_axi4_rlast,
    output logic [C_AXI_USER_WIDTH-1:0] s_axi4_ruser,
    output logic                        s_axi4_rvalid,
    input  logic                        s_axi4_rready,

    input  logic [C_AXI_ID_WIDTH-1:0]   m_axi4_rid,
    input  logic [C_AXI_DATA_WIDTH-1:0] m_axi4_rdata,
    input  logic [1:0]                  m_axi4_rresp,
    input  logic                        m_axi4_rlast,
    input  logic [C_AXI_USER_WIDTH-1:0] m_axi4_ruser,
    input  logic                        m_axi4_rvalid,
    output logic                        m_axi4_rready
);

    localparam int unsigned EntryWidth = drop_entry_width(C_AXI_ID_WIDTH);

    typedef enum logic [0:0] {StIdle, StDrop} state_e;

    state_e                    state_q;
    logic [DropLenWidth-1:0]   beat_cnt_q;
    logic                      m_burst_active_q;

    logic [EntryWidth-1:0]     fifo_data;
    logic                      fifo_valid;
    logic                      fifo_pop;
    logic [C_AXI_ID_WIDTH-1:0] fifo_id;
    logic [DropLenWidth-1:0]   fifo_len;
    logic                      drop_last;
    logic                      m_hs;

    axi_buffer_rab #(
        .DATA_WIDTH   (EntryWidth),
        .BUFFER_DEPTH (4)
    ) u_drop_fifo (
        .clk       (axi4_aclk),
        .rstn      (axi4_arstn),
        .data_out  (fifo_data),
        .valid_out (fifo_valid),
        .ready_in  (fifo_pop),
        .valid_in  (trans_drop),
        .data_in   ({trans_id, trans_len}),
        .ready_out (drop_ready)
    );

    assign fifo_id   = fifo_data[EntryWidth-1 -: C_AXI_ID_WIDTH];
    assign fifo_len  = fifo_data[DropLenWidth-1:0];
    // Equality compare: len=255 yields 256 beats without a wrapping counter.
    assign drop_last = (beat_cnt_q == fifo_len);
    assign fifo_pop  = (state_q == StDrop) & s_axi4_rready & drop_last;
    assign m_hs      = m_axi4_rvalid & m_axi4_rready;

    always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
        if (!axi4_arstn) begin
            state_q          <= StIdle;
            beat_cnt_q       <= '0;
            m_burst_active_q <= 1'b0;
        end else begin
            if (m_hs) begin
                m_burst_active_q <= ~m_axi4_rlast;
            end
            case (state_q)
                StIdle: begin
                    if (fifo_valid && !m_axi4_rvalid && !m_burst_active_q) begin
                        state_q <= StDrop;
                    end
                end
                StDrop: begin
                    if (s_axi4_rready) begin
                        if (drop_last) begin
                            beat_cnt_q <= '0;
                            state_q    <= StIdle;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        s_axi4_rid    = m_axi4_rid;
        s_axi4_rdata  = m_axi4_rdata;
        s_axi4_rresp  = m_axi4_rresp;
        s_axi4_rlast  = m_axi4_rlast;
        s_axi4_ruser  = m_axi4_ruser;
        s_axi4_rvalid = m_axi4_rvalid;
        m_axi4_rready = s_axi4_rready;
        if (state_q == StDrop) begin
            s_axi4_rid    = fifo_id;
            s_axi4_rdata  = '0;
            s_axi4_rresp  = C_DROP_RESP;
            s_axi4_rlast  = drop_last;
            s_axi4_ruser  = '0;
            s_axi4_rvalid = 1'b1;
            m_axi4_rready = 1'b0;
        end
    end

endmodule

// File: tb/tb_axi4_rdrop_responder.sv
// Scoreboard bench: stimulus queues expected R beats, a negedge monitor checks every s-side beat.
module tb_axi4_rdrop_responder;

    localparam int IDW = 10;
    localparam int DW  = 64;
    localparam int UW  = 4;

    logic           axi4_aclk = 1'b0;
    logic           axi4_arstn;
    logic [IDW-1:0] trans_id;
    logic [7:0]     trans_len;
    logic           trans_drop;
    logic           drop_ready;
    logic [IDW-1:0] s_rid, m_rid;
    logic [DW-1:0]  s_rdata, m_rdata;
    logic [1:0]     s_rresp, m_rresp;
    logic           s_rlast, m_rlast;
    logic [UW-1:0]  s_ruser, m_ruser;
    logic           s_rvalid, m_rvalid;
    logic           s_rready, m_rready;

    always #5 axi4_aclk = ~axi4_aclk;

    axi4_rdrop_responder dut (
        .axi4_aclk     (axi4_aclk),
        .axi4_arstn    (axi4_arstn),
        .trans_id      (trans_id),
        .trans_len     (trans_len),
        .trans_drop    (trans_drop),
        .drop_ready    (drop_ready),
        .s_axi4_rid    (s_rid),
        .s_axi4_rdata  (s_rdata),
        .s_axi4_rresp  (s_rresp),
        .s_axi4_rlast  (s_rlast),
        .s_axi4_ruser  (s_ruser),
        .s_axi4_rvalid (s_rvalid),
        .s_axi4_rready (s_rready),
        .m_axi4_rid    (m_rid),
        .m_axi4_rdata  (m_rdata),
        .m_axi4_rresp  (m_rresp),
        .m_axi4_rlast  (m_rlast),
        .m_axi4_ruser  (m_ruser),
        .m_axi4_rvalid (m_rvalid),
        .m_axi4_rready (m_rready)
    );

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [DW-1:0]  data;
        logic [1:0]     resp;
        logic           last;
        logic [UW-1:0]  user;
    } beat_t;

    beat_t exp_q[$];
    int    total = 0;
    int    bad   = 0;
    int    hs_cnt = 0;
    beat_t held;
    bit    held_v = 1'b0;

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    task automatic fail_now(input string nm);
        total++;
        bad++;
        $display("FAIL %s", nm);
    endtask

    // Monitor: compare every accepted beat; a stalled beat must not change.
    always @(negedge axi4_aclk) begin
        beat_t act;
        beat_t e;
        if (axi4_arstn && s_rvalid) begin
            act.id   = s_rid;
            act.data = s_rdata;
            act.resp = s_rresp;
            act.last = s_rlast;
            act.user = s_ruser;
            if (held_v) chk("stall_stable", 96'(act), 96'(held));
            if (s_rready) begin
                hs_cnt++;
                held_v = 1'b0;
                if (exp_q.size() == 0) begin
                    fail_now($sformatf("unexpected_beat id=%h last=%b", act.id, act.last));
                end else begin
                    e = exp_q.pop_front();
                    chk("beat", 96'(act), 96'(e));
                end
            end else begin
                held   = act;
                held_v = 1'b1;
            end
        end else begin
            held_v = 1'b0;
        end
    end

    task automatic exp_drop(input logic [IDW-1:0] id, input int len, input int nbeats);
        beat_t b;
        for (int i = 0; i < nbeats; i++) begin
            b.id = id; b.data = '0; b.resp = 2'b10; b.last = (i == len); b.user = '0;
            exp_q.push_back(b);
        end
    endtask

    task automatic exp_m(input logic [IDW-1:0] id, input int len, input logic [31:0] seed);
        beat_t b;
        for (int i = 0; i <= len; i++) begin
            b.id = id; b.data = {seed, 32'(i)}; b.resp = 2'b01; b.last = (i == len);
            b.user = UW'(i);
            exp_q.push_back(b);
        end
    endtask

    task automatic push_drop(input logic [IDW-1:0] id, input logic [7:0] len);
        int n = 0;
        trans_id = id; trans_len = len; trans_drop = 1'b1;
        do begin @(negedge axi4_aclk); n++; end while (!drop_ready && n < 2000);
        if (!drop_ready) fail_now("push_timeout");
        @(posedge axi4_aclk); #1;
        trans_drop = 1'b0;
    endtask

    task automatic m_burst(input logic [IDW-1:0] id, input int len, input logic [31:0] seed);
        for (int i = 0; i <= len; i++) begin
            int n = 0;
            m_rvalid = 1'b1; m_rid = id; m_rdata = {seed, 32'(i)}; m_rresp = 2'b01;
            m_rlast = (i == len); m_ruser = UW'(i);
            do begin @(negedge axi4_aclk); n++; end while (!m_rready && n < 2000);
            if (!m_rready) fail_now("m_hs_timeout");
            @(posedge axi4_aclk); #1;
        end
        m_rvalid = 1'b0; m_rlast = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin @(posedge axi4_aclk); n++; end
        chk(nm, 96'(exp_q.size()), 96'(0));
        repeat (2) @(posedge axi4_aclk);
        #1;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        axi4_arstn = 1'b0;
        trans_id = '0; trans_len = '0; trans_drop = 1'b0;
        s_rready = 1'b1;
        m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0; m_ruser = '0; m_rvalid = 1'b0;
        repeat (3) @(posedge axi4_aclk);
        #1;
        chk("rst_s_rvalid", 96'(s_rvalid), 96'(0));
        chk("rst_drop_ready", 96'(drop_ready), 96'(1));
        chk("rst_m_rready", 96'(m_rready), 96'(1));
        axi4_arstn = 1'b1;
        repeat (2) @(posedge axi4_aclk);
        #1;

        // 1: single drop, one-cycle latency
        exp_drop(10'h015, 0, 1);
        push_drop(10'h015, 8'd0);
        chk("t1_no_beat_yet", 96'(s_rvalid), 96'(0));
        @(posedge axi4_aclk); #1;
        chk("t1_beat_valid", 96'(s_rvalid), 96'(1));
        chk("t1_m_rready", 96'(m_rready), 96'(0));
        drain("t1_drain");
        chk("t1_idle", 96'(s_rvalid), 96'(0));

        // 2: 4-beat drop with toggling rready
        exp_drop(10'h003, 3, 4);
        fork
            push_drop(10'h003, 8'd3);
            begin
                repeat (16) begin @(posedge axi4_aclk); #1; s_rready = ~s_rready; end
                s_rready = 1'b1;
            end
        join
        drain("t2_drain");

        // 3: drop arrives mid master burst
        exp_m(10'h101, 7, 32'hA5A5_0003);
        exp_drop(10'h03A, 2, 3);
        fork
            m_burst(10'h101, 7, 32'hA5A5_0003);
            begin repeat (3) @(posedge axi4_aclk); #1; push_drop(10'h03A, 8'd2); end
        join
        drain("t3_drain");

        // 4: two queued drops, master raised during the first
        exp_drop(10'h021, 1, 2);
        exp_m(10'h2F0, 3, 32'h0000_BEEF);
        exp_drop(10'h022, 255, 256);
        push_drop(10'h021, 8'd1);
        push_drop(10'h022, 8'd255);
        m_burst(10'h2F0, 3, 32'h0000_BEEF);
        drain("t4_drain");

        // 5: fill the FIFO, hold a push while full
        s_rready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_drop(IDW'(10'h040 + i), 0, 1);
            push_drop(IDW'(10'h040 + i), 8'd0);
        end
        exp_drop(10'h044, 0, 1);
        exp_drop(10'h045, 0, 1);
        @(negedge axi4_aclk);
        chk("t5_full", 96'(drop_ready), 96'(0));
        fork
            begin push_drop(10'h044, 8'd0); push_drop(10'h045, 8'd0); end
            begin
                repeat (4) begin
                    @(negedge axi4_aclk);
                    chk("t5_held_full", 96'(drop_ready), 96'(0));
                end
                @(posedge axi4_aclk); #1;
                s_rready = 1'b1;
            end
        join
        drain("t5_drain");

        // 6: reset in the middle of an injected burst
        base = hs_cnt;
        exp_drop(10'h02C, 3, 2);
        push_drop(10'h02C, 8'd3);
        n = 0;
        do begin @(negedge axi4_aclk); #1; n++; end while (hs_cnt < base + 2 && n < 100);
        if (hs_cnt < base + 2) fail_now("t6_wait_timeout");
        @(posedge axi4_aclk); #1;
        axi4_arstn = 1'b0;
        s_rready = 1'b0;
        m_rvalid = 1'b1; m_rid = 10'h155; m_rresp = 2'b11; m_rlast = 1'b1;
        #1;
        chk("t6_rst_valid", 96'(s_rvalid), 96'(1));
        chk("t6_rst_rid", 96'(s_rid), 96'(10'h155));
        chk("t6_rst_rresp", 96'(s_rresp), 96'(2'b11));
        m_rvalid = 1'b0; m_rlast = 1'b0;
        #1;
        chk("t6_rst_novalid", 96'(s_rvalid), 96'(0));
        chk("t6_rst_drop_ready", 96'(drop_ready), 96'(1));
        @(posedge axi4_aclk); #1;
        axi4_arstn = 1'b1;
        s_rready = 1'b1;
        repeat (20) @(posedge axi4_aclk);
        #1;
        chk("t6_no_residual", 96'(s_rvalid), 96'(0));
        chk("t6_queue_empty", 96'(exp_q.size()), 96'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
